// File: rtl/signal_shrink_if.sv
// signal_shrink_if: the event-side signals of signal_shrink, grouped into one bundle.
//   master : the source of the stretched level. It drives i_vld and i_vld_data
//            and observes the response pulses.
//   slave  : the shrinker itself. It receives i_vld and i_vld_data and drives
//            o_vld, o_vld_data, o_err_short, o_err_long, o_err_data and o_busy.
interface signal_shrink_if;
  logic i_vld;
  logic i_vld_data;
  logic o_vld;
  logic o_vld_data;
  logic o_err_short;
  logic o_err_long;
  logic o_err_data;
  logic o_busy;

  modport master (
    output i_vld, i_vld_data,
    input  o_vld, o_vld_data, o_err_short, o_err_long, o_err_data, o_busy
  );

  modport slave (
    input  i_vld, i_vld_data,
    output o_vld, o_vld_data, o_err_short, o_err_long, o_err_data, o_busy
  );
endinterface

// File: rtl/signal_shrink.sv
// signal_shrink: receive-side pulse shrinker.
//
// The block measures the width of each high level on i_vld. A level whose width
// lies within [MIN_CYC_NUM, MAX_CYC_NUM] collapses into one single-cycle o_vld
// pulse. That pulse carries the data bit sampled in the first high cycle.
// Widths outside that range produce one-cycle pulses on o_err_short or
// o_err_long instead. All outputs are registered.
//
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : signal_shrink_if.slave, which carries these signals:
//             i_vld, i_vld_data   stretched level and its data bit
//             o_vld, o_vld_data   accepted-event pulse and its data
//             o_err_short         level ended with width < MIN_CYC_NUM
//             o_err_long          level width exceeded MAX_CYC_NUM
//             o_err_data          data changed within a valid-width level
//             o_busy              a level is being measured
//
// Optional feature: macro SIGNAL_SHRINK_DATA_CHK_EN.
//   When it is defined, the block tracks data changes within a level. A level of
//   valid width whose data changed reports o_err_data instead of o_vld.
//   When it is undefined, o_err_data is tied to 0.
module signal_shrink #(
  parameter int MIN_CYC_NUM = 12,
  parameter int MAX_CYC_NUM = 24
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  signal_shrink_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_CYC_NUM + 2);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CYC_NUM);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYC_NUM);

  // WAIT_LOW is the reset state. A level that is already high when reset
  // releases therefore never counts as an event.
  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_cap_q, data_cap_d;
  logic             vld_q, vld_d;
  logic             vld_data_q, vld_data_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic             busy_q, busy_d;
`ifdef SIGNAL_SHRINK_DATA_CHK_EN
  logic             mism_q, mism_d;
  logic             err_data_q, err_data_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_cap_d  = data_cap_q;
    vld_d       = 1'b0;
    vld_data_d  = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
`ifdef SIGNAL_SHRINK_DATA_CHK_EN
    mism_d      = mism_q;
    err_data_d  = 1'b0;
`endif
    unique case (state_q)
      WAIT_LOW: begin
        if (!bus.i_vld) state_d = IDLE;
      end
      IDLE: begin
        if (bus.i_vld) begin
          state_d    = HIGH;
          cnt_d      = CNT_W'(1);
          data_cap_d = bus.i_vld_data;
`ifdef SIGNAL_SHRINK_DATA_CHK_EN
          mism_d     = 1'b0;
`endif
        end
      end
      HIGH: begin
        if (bus.i_vld) begin
          if (cnt_q < MAX_C) begin
            cnt_d  = cnt_q + CNT_W'(1);
`ifdef SIGNAL_SHRINK_DATA_CHK_EN
            mism_d = mism_q | (bus.i_vld_data != data_cap_q);
`endif
          end else begin
            // This is high sample MAX+1. Report the error now. WAIT_LOW then
            // absorbs the rest of the level without a second pulse.
            err_long_d = 1'b1;
            state_d    = WAIT_LOW;
          end
        end else begin
          state_d = IDLE;
          if (cnt_q < MIN_C) begin
            err_short_d = 1'b1;
          end else begin
`ifdef SIGNAL_SHRINK_DATA_CHK_EN
            if (mism_q) begin
              err_data_d = 1'b1;
            end else begin
              vld_d      = 1'b1;
              vld_data_d = data_cap_q;
            end
`else
            vld_d      = 1'b1;
            vld_data_d = data_cap_q;
`endif
          end
        end
      end
      default: state_d = WAIT_LOW;
    endcase
    busy_d = (state_d == HIGH);
  end

  // Control and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= WAIT_LOW;
      cnt_q       <= '0;
      vld_q       <= 1'b0;
      vld_data_q  <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SIGNAL_SHRINK_DATA_CHK_EN
      mism_q      <= 1'b0;
      err_data_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      vld_data_q  <= vld_data_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      busy_q      <= busy_d;
`ifdef SIGNAL_SHRINK_DATA_CHK_EN
      mism_q      <= mism_d;
      err_data_q  <= err_data_d;
`endif
    end
  end

  // Captured data bit. It is only read while in HIGH, so it needs no reset.
  always_ff @(posedge i_clk) begin
    data_cap_q <= data_cap_d;
  end

  assign bus.o_vld       = vld_q;
  assign bus.o_vld_data  = vld_data_q;
  assign bus.o_err_short = err_short_q;
  assign bus.o_err_long  = err_long_q;
  assign bus.o_busy      = busy_q;
`ifdef SIGNAL_SHRINK_DATA_CHK_EN
  assign bus.o_err_data  = err_data_q;
`else
  assign bus.o_err_data  = 1'b0;
`endif

endmodule

// File: doc/signal_shrink.md
Name: signal_shrink

Overview:
- Receive-side counterpart of the team's pulse stretcher.
- Qualifies a stretched level on i_vld by its width and collapses each accepted level into one single-cycle o_vld pulse carrying the qualified data bit.
- Widths outside [MIN_CYC_NUM, MAX_CYC_NUM] are rejected with one-cycle error pulses.
- Sits at the far end of slow or level-crossing control paths (e.g. after a synchroniser) where events travel as stretched pulses.

Parameters:
- MIN_CYC_NUM, 12: minimum accepted high width in cycles; must be >= 1. Default matches the team's standard 12-cycle stretch.
- MAX_CYC_NUM, 24: maximum accepted high width in cycles; must be >= MIN_CYC_NUM.
- CNT_W (localparam), $clog2(MAX_CYC_NUM+2): width counter size.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  synchronous active-low reset, sampled on posedge i_clk
- i_vld  input  1  stretched valid level
- i_vld_data  input  1  data bit accompanying i_vld
- o_vld  output  1  one-cycle pulse, accepted event
- o_vld_data  output  1  data of the accepted event; valid only with o_vld, 0 otherwise
- o_err_short  output  1  one-cycle pulse, level ended with width < MIN_CYC_NUM
- o_err_long  output  1  one-cycle pulse, level width exceeded MAX_CYC_NUM
- o_err_data  output  1  one-cycle pulse, data mismatch (optional feature only; 0 otherwise)
- o_busy  output  1  high while a level is being measured (state HIGH)

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous, active-low i_rst_n. No asynchronous reset path.
- Outputs: all registered; every output resets to 0.
- States: WAIT_LOW, IDLE, HIGH. Reset state is WAIT_LOW, so a level already high at reset release is never counted as an event.
- WAIT_LOW: i_vld=0 -> IDLE; otherwise stay. No outputs.
- IDLE: i_vld=1 -> HIGH; cnt<=1; data_cap<=i_vld_data; mism<=0.
- HIGH, i_vld=1 and cnt<MAX_CYC_NUM:
  - cnt<=cnt+1.
  - mism<=mism | (i_vld_data != data_cap).
- HIGH, i_vld=1 and cnt==MAX_CYC_NUM (this is the (MAX+1)th high cycle):
  - o_err_long=1 next cycle; -> WAIT_LOW.
  - No further output for this level.
- HIGH, i_vld=0, width W = cnt:
  - W < MIN_CYC_NUM: o_err_short=1 next cycle.
  - Otherwise: o_vld=1 and o_vld_data=data_cap next cycle.
  - -> IDLE.
- Latency: response pulse is high exactly one cycle, in the cycle after the first edge at which i_vld is sampled low.
- Back-to-back levels: a single low cycle between levels is sufficient. Each level yields exactly one response pulse.
- Exclusivity: at most one of o_vld / o_err_short / o_err_long / o_err_data is high in any cycle.
- o_busy: registered; 1 in every cycle following an edge that left the FSM in HIGH.
- Counter: never exceeds MAX_CYC_NUM+1; no wrap-around.
- Reset mid-level: any level in progress is discarded with no response pulse; FSM re-enters WAIT_LOW.

Optional Feature:
- Macro: SIGNAL_SHRINK_DATA_CHK_EN.
- Defined: a level of valid width with mism=1 at its fall produces o_err_data=1 for one cycle instead of o_vld. Width errors take precedence over the data error.
- Undefined: mism logic is not built; o_err_data is tied 0; o_vld_data is the first-cycle sample regardless of later i_vld_data changes.

Test Plan:
- Reset release with i_vld held high for 30 cycles, then low -> no pulse on any output; a following 12-cycle level with data=1 -> o_vld=1, o_vld_data=1.
- i_vld high 12 cycles, i_vld_data=1 -> o_vld=1 for one cycle, exactly 1 cycle after first low sample; o_vld_data=1. Repeat with 24 cycles, data=0 -> o_vld=1, o_vld_data=0.
- i_vld high 11 cycles -> o_err_short=1 one cycle; o_vld stays 0. i_vld high 1 cycle -> same.
- i_vld high 40 cycles -> o_err_long=1 the cycle after the 25th high sample; nothing at the fall; o_busy drops with it.
- Two 12-cycle levels separated by one low cycle, data 1 then 0 -> two o_vld pulses, data 1 then 0; o_busy low for exactly one cycle between them.
- Data toggles at cycle 5 of a 12-cycle level, data=1 first -> with SIGNAL_SHRINK_DATA_CHK_EN: o_err_data=1, o_vld=0; without it: o_vld=1, o_vld_data=1. Reset asserted at cycle 6 of a level -> no pulse afterwards.
